fifo_frame_packer: RTL
======================

// Module: fifo_frame_packer
// PURPOSE
//  Read-side consumer of the 16-bit dual-clock FIFO. Pops words on rclk whenever the FIFO is non-empty and
//  downstream has room. Groups every FRAME_LEN data words into a frame, then appends one 16-bit checksum word.
//  Presents frames on a valid/ready stream with sof/eof markers. Buffering is a 2-entry skid buffer, so
//  backpressure never drops or duplicates a FIFO word.
// PARAMETERS
//  DW        16  data word width
//  FRAME_LEN 10  data words per frame (>=1); checksum word follows
//  CNT_W     4   width of word/request counters; must hold FRAME_LEN
// PORTS
//  rclk       in   1   clock (FIFO read clock)
//  rst_n      in   1   asynchronous reset, active low
//  fifo_empty in   1   FIFO empty flag
//  fifo_dout  in   DW  FIFO read data, valid 1 cycle after an accepted read
//  fifo_rd_en out  1   FIFO pop request
//  m_valid    out  1   output word valid
//  m_ready    in   1   downstream accepts word when m_valid&&m_ready
//  m_data     out  DW  output word (data or checksum)
//  m_sof      out  1   first data word of frame
//  m_eof      out  1   checksum word (last of frame)
//  frame_cnt  out  16  completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (async, rst_n=0): m_valid=0, m_data=0, m_sof=0, m_eof=0, frame_cnt=0, fifo_rd_en=0,
//   buffer emptied, in-flight read dropped, FSM=S_DATA, word/req counters=0, checksum=0.
//  fifo_rd_en = !fifo_empty && (buf_cnt + inflight < 2) && (req_cnt < FRAME_LEN) && rst_n.
//   Combinational. Each high cycle is one pop. inflight=1 in the cycle after a pop.
//   On that cycle fifo_dout is written to the buffer tail.
//  Latency: rd_en high at cycle t -> word in buffer at t+1 edge -> m_valid/m_data at t+2.
//  Buffer: FIFO order, 2 entries. Head drives m_data in S_DATA. Pop only on accept.
//   Simultaneous write+pop allowed.
//  FSM S_DATA: m_valid=(buf_cnt>0), m_sof=(word_idx==0), m_eof=0. Per accepted word:
//   checksum+=word (mod 2^DW, carries discarded), word_idx++.
//   Accepting word_idx==FRAME_LEN-1 -> S_CKSUM.
//  FSM S_CKSUM: m_valid=1, m_data=checksum (includes last data word), m_sof=0, m_eof=1.
//   On accept: checksum=0, word_idx=0, req_cnt=0, frame_cnt++, -> S_DATA.
//  req_cnt increments per pop and saturates at FRAME_LEN. No next-frame prefetch until the checksum is accepted.
//  m_valid && !m_ready: m_data/m_sof/m_eof held stable; no word lost or repeated.
//  fifo_empty mid-frame: m_valid drops once the buffer drains. Frame resumes; sof not reasserted.
//  Reset mid-frame: the partial frame is discarded. The next word out carries m_sof=1 and a fresh checksum.
//  fifo_rd_en never asserts while fifo_empty=1.
// TESTING
//  1 rst_n=0 with random inputs -> all outputs 0, fifo_rd_en=0; release -> still idle while fifo_empty=1.
//  2 FRAME_LEN=4, FIFO words 0x0001..0x0004, m_ready=1 -> beats 1,2,3,4,0x000A. sof on 0x0001, eof on 0x000A.
//    frame_cnt=1.
//  3 FRAME_LEN=4, words 0xFFFF x4 -> checksum beat 0xFFFC with m_eof=1.
//  4 m_ready=0 for 6 cycles mid-frame -> m_data stable, exactly 2 words buffered, fifo_rd_en=0 after.
//    Order intact on release.
//  5 fifo_empty toggled every other cycle over 3 frames -> no duplicate/missing words, checksums correct,
//    frame_cnt=3.
//  6 rst_n pulsed after 2 of 4 words -> next output word has m_sof=1, its frame checksum excludes pre-reset words.

Source files
------------

// File: rtl/fifo_frame_packer_if.sv
// rtl/fifo_frame_packer_if.sv - FIFO read-side and output stream bundle for fifo_frame_packer
//
// Ports carried:
//   fifo_empty  FIFO empty flag            (env -> packer)
//   fifo_dout   FIFO read data             (env -> packer), valid one cycle after a pop
//   fifo_rd_en  FIFO pop request           (packer -> env)
//   m_valid     output word valid          (packer -> env)
//   m_ready     downstream ready           (env -> packer)
//   m_data      output word                (packer -> env)
//   m_sof       first data word of frame   (packer -> env)
//   m_eof       checksum word of frame     (packer -> env)
// master = the packer, slave = the FIFO / downstream side.
interface fifo_frame_packer_if #(
  parameter int DW = 16
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eof;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, m_sof, m_eof
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_sof, m_eof
  );
endinterface

// File: rtl/fifo_frame_packer.sv
// rtl/fifo_frame_packer.sv - packs FIFO words into checksummed frames on a valid/ready stream
//
// Pops the read side of a dual-clock FIFO, groups every FRAME_LEN data words into a
// frame and appends one checksum word (sum of the frame's data words, carries dropped).
// Ports:
//   rclk       FIFO read clock
//   rst_n      asynchronous reset, active low
//   bus        fifo_frame_packer_if.master (fifo_empty/fifo_dout/fifo_rd_en,
//              m_valid/m_ready/m_data/m_sof/m_eof)
//   frame_cnt  completed frames, wraps 0xFFFF -> 0
module fifo_frame_packer #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 10,
  parameter int CNT_W     = 4
) (
  input  logic                 rclk,
  input  logic                 rst_n,
  fifo_frame_packer_if.master  bus,
  output logic [15:0]          frame_cnt
);

  typedef enum logic {S_DATA, S_CKSUM} state_t;

  localparam logic [CNT_W-1:0] LEN      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t         state;
  logic [DW-1:0]  buf_q [2];
  logic [1:0]     buf_cnt;
  logic           inflight;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] word_idx;
  logic [DW-1:0]  checksum;

  logic           rd_en;
  logic           accept;
  logic           buf_pop;
  logic [2:0]     occupancy;

  // A word already requested but not yet landed still needs a buffer slot,
  // so it counts against the two entries; this is what makes backpressure lossless.
  assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};
  assign rd_en     = !bus.fifo_empty && (occupancy < 3'd2) && (req_cnt < LEN) && rst_n;

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (state == S_CKSUM) || (buf_cnt != 2'd0);
  assign bus.m_data     = (state == S_CKSUM) ? checksum : buf_q[0];
  assign bus.m_sof      = (state == S_DATA) && (buf_cnt != 2'd0) && (word_idx == '0);
  assign bus.m_eof      = (state == S_CKSUM);

  assign accept  = bus.m_valid && bus.m_ready;
  assign buf_pop = accept && (state == S_DATA);

  // Two-entry buffer, entry 0 is the head. A landing word goes to the first free
  // slot after any same-cycle pop has shifted the head out.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (buf_pop) begin
        buf_q[0] <= buf_q[1];
      end
      if (inflight) begin
        if ((buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && buf_pop)) begin
          buf_q[0] <= bus.fifo_dout;
        end else begin
          buf_q[1] <= bus.fifo_dout;
        end
      end
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, buf_pop};
    end
  end

  // Frame sequencing. req_cnt stops further pops once a whole frame has been
  // requested, so the next frame is not prefetched until its checksum leaves.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DATA;
      word_idx  <= '0;
      req_cnt   <= '0;
      checksum  <= '0;
      frame_cnt <= 16'd0;
    end else begin
      if (rd_en && (req_cnt != LEN)) begin
        req_cnt <= req_cnt + ONE;
      end
      case (state)
        S_DATA: begin
          if (accept) begin
            checksum <= checksum + bus.m_data;
            word_idx <= word_idx + ONE;
            if (word_idx == LAST_IDX) begin
              state <= S_CKSUM;
            end
          end
        end
        S_CKSUM: begin
          if (accept) begin
            checksum  <= '0;
            word_idx  <= '0;
            req_cnt   <= '0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= S_DATA;
          end
        end
        default: state <= S_DATA;
      endcase
    end
  end

endmodule
